// File: rtl/seven_segment_scan_ctrl_pkg.sv
// Shared constants, FSM encoding and glyph table
// for the dual-digit 7-segment scan controller.
package seven_segment_scan_ctrl_pkg;

  localparam int F_CLK_12M_HZ = 12_000_000;
  localparam int F_REFRESH_HZ = 100;
  localparam int F_SLOT_12M   = F_CLK_12M_HZ / (2 * F_REFRESH_HZ);
  localparam int F_GAP_12M    = 120;

  typedef enum logic [1:0] {
    SHOW_HI = 2'd0,
    GAP_HL  = 2'd1,
    SHOW_LO = 2'd2,
    GAP_LH  = 2'd3
  } scan_state_t;

  // gfedcba, entry 15 first so SEG_TABLE[n] is glyph n
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seven_segment_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to segment glyph
// lookup, 1 = segment lit.
module hex_to_seg
  import seven_segment_scan_ctrl_pkg::*;
#(
  parameter int DW = 7
) (
  input  logic [3:0]    i_nib,
  output logic [DW-1:0] o_seg
);

  assign o_seg = DW'(SEG_TABLE[i_nib]);

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Two-digit multiplexed 7-segment driver with
// frame-aligned value update and blanking gaps.
module seven_segment_scan_ctrl
  import seven_segment_scan_ctrl_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 7,
  parameter int SLOT_CYCLES = F_SLOT_12M,
  parameter int GAP_CYCLES  = F_GAP_12M
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] value_in,
  input  logic          value_valid,
  output logic          value_ready,
  input  logic          blank,
  input  logic          lz_blank,
  output logic [DW-1:0] led_port,
  output logic          c,
  output logic          frame
);

  localparam int CW = $clog2(max2(SLOT_CYCLES, GAP_CYCLES));
  localparam logic [CW-1:0] SLOT_LD = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  scan_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_active;
  logic [AW-1:0] r_pending;
  logic          r_pend_full;
  logic [DW-1:0] r_led;
  logic          r_c;
  logic          r_frame;

  scan_state_t   w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_active_nxt;
  logic [3:0]    w_nib;
  logic [DW-1:0] w_seg;
  logic [DW-1:0] w_led_nxt;
  logic          w_bound;
  logic          w_accept;

  assign w_bound  = (r_state == GAP_LH) && (r_cnt == '0);
  assign w_accept = value_valid && !r_pend_full;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - 1'b1;
    if (r_cnt == '0) begin
      unique case (r_state)
        SHOW_HI: begin
          w_state_nxt = GAP_HL;
          w_cnt_nxt   = GAP_LD;
        end
        GAP_HL: begin
          w_state_nxt = SHOW_LO;
          w_cnt_nxt   = SLOT_LD;
        end
        SHOW_LO: begin
          w_state_nxt = GAP_LH;
          w_cnt_nxt   = GAP_LD;
        end
        GAP_LH: begin
          w_state_nxt = SHOW_HI;
          w_cnt_nxt   = SLOT_LD;
        end
        default: begin
          w_state_nxt = GAP_LH;
          w_cnt_nxt   = GAP_LD;
        end
      endcase
    end
  end

  // Outputs are computed from the state being entered so
  // they change on the same edge as the state itself.
  assign w_active_nxt = (w_bound && r_pend_full) ? r_pending : r_active;
  assign w_nib = (w_state_nxt == SHOW_HI) ? w_active_nxt[AW-1:4]
                                          : w_active_nxt[3:0];

  hex_to_seg #(
    .DW(DW)
  ) u_hex_to_seg (
    .i_nib(w_nib),
    .o_seg(w_seg)
  );

  always_comb begin
    w_led_nxt = '0;
    unique case (1'b1)
      (w_state_nxt == SHOW_HI): begin
        if (!(lz_blank && w_nib == 4'h0))
          w_led_nxt = w_seg;
      end
      (w_state_nxt == SHOW_LO): w_led_nxt = w_seg;
      default: w_led_nxt = '0;
    endcase
    if (blank)
      w_led_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= GAP_LH;
      r_cnt       <= GAP_LD;
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
      r_led       <= '0;
      r_c         <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_active    <= w_active_nxt;
      if (w_accept)
        r_pending <= value_in;
      r_pend_full <= w_accept | (r_pend_full & ~w_bound);
      r_led       <= w_led_nxt;
      r_c         <= (w_state_nxt == SHOW_HI) ||
                     (w_state_nxt == GAP_HL);
      r_frame     <= w_bound;
    end
  end

  assign value_ready = ~r_pend_full;
  assign led_port    = r_led;
  assign c           = r_c;
  assign frame       = r_frame;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed bench for seven_segment_scan_ctrl
// with SLOT_CYCLES=4, GAP_CYCLES=2.
module tb_seven_segment_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] value_in;
  logic       value_valid;
  logic       value_ready;
  logic       blank;
  logic       lz_blank;
  logic [6:0] led_port;
  logic       c;
  logic       frame;

  int n_pass;
  int n_total;
  int cyc;

  seven_segment_scan_ctrl #(
    .AW(8),
    .DW(7),
    .SLOT_CYCLES(4),
    .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value_in(value_in),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .blank(blank),
    .lz_blank(lz_blank),
    .led_port(led_port),
    .c(c),
    .frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int phase();
    return (cyc - 2) % 12;
  endfunction

  task automatic to_phase(input int p);
    for (int k = 0; k < 12; k++) begin
      if (phase() == p)
        break;
      step();
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  logic       pc;
  logic [6:0] pl;
  int         run;
  int         nf;
  int         nedge;

  initial begin
    n_pass = 0;
    n_total = 0;
    cyc = 0;
    reset = 1'b1;
    value_in = 8'h00;
    value_valid = 1'b0;
    blank = 1'b0;
    lz_blank = 1'b0;

    repeat (3) step();
    chk("rst_led", led_port, 7'h00);
    chk("rst_c", c, 1'b0);
    chk("rst_frame", frame, 1'b0);
    chk("rst_ready", value_ready, 1'b1);

    reset = 1'b0;
    cyc = 0;
    chk("rel0_led", led_port, 7'h00);
    chk("rel0_c", c, 1'b0);
    step();
    chk("rel1_led", led_port, 7'h00);
    chk("rel1_c", c, 1'b0);
    chk("rel1_frame", frame, 1'b0);
    step();
    chk("first_frame", frame, 1'b1);
    chk("first_led", led_port, 7'h3F);
    chk("first_c", c, 1'b1);

    nf = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (frame) nf++;
    end
    chk("no_extra_frame", nf, 0);
    step();
    chk("frame_period", frame, 1'b1);

    pc = c;
    pl = led_port;
    run = 0;
    nedge = 0;
    for (int i = 0; i < 36; i++) begin
      step();
      if (c !== pc) begin
        nedge++;
        chk("c_edge_dark", {31'd0, pl == 7'h00}, 1);
      end
      if (led_port == 7'h00) begin
        run++;
      end else begin
        if (run != 0)
          chk("gap_len", run, 2);
        run = 0;
      end
      pc = c;
      pl = led_port;
    end
    chk("c_edges", nedge, 6);

    to_phase(7);
    chk("a5_ready_pre", value_ready, 1'b1);
    value_in = 8'hA5;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    chk("a5_ready_drop", value_ready, 1'b0);
    to_phase(0);
    chk("a5_frame", frame, 1'b1);
    chk("a5_hi", led_port, 7'h77);
    chk("a5_hi_c", c, 1'b1);
    chk("a5_ready_back", value_ready, 1'b1);
    to_phase(6);
    chk("a5_lo", led_port, 7'h6D);
    chk("a5_lo_c", c, 1'b0);

    to_phase(2);
    value_in = 8'h12;
    value_valid = 1'b1;
    step();
    chk("b2b_12_acc", value_ready, 1'b0);
    value_in = 8'h34;
    to_phase(0);
    chk("b2b_12_hi", led_port, 7'h06);
    chk("b2b_12_frame", frame, 1'b1);
    chk("b2b_ready_at_frame", value_ready, 1'b1);
    step();
    value_valid = 1'b0;
    chk("b2b_34_acc", value_ready, 1'b0);
    to_phase(6);
    chk("b2b_12_lo", led_port, 7'h5B);
    to_phase(0);
    chk("b2b_34_hi", led_port, 7'h4F);
    chk("b2b_34_ready", value_ready, 1'b1);
    to_phase(6);
    chk("b2b_34_lo", led_port, 7'h66);

    to_phase(2);
    value_in = 8'h07;
    value_valid = 1'b1;
    lz_blank = 1'b1;
    step();
    value_valid = 1'b0;
    to_phase(0);
    chk("lz_hi", led_port, 7'h00);
    chk("lz_hi_c", c, 1'b1);
    to_phase(6);
    chk("lz_lo", led_port, 7'h07);
    step();
    blank = 1'b1;
    lz_blank = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("blank_led", led_port, 7'h00);
      chk("blank_c", c, {31'd0, phase() < 6});
    end
    blank = 1'b0;
    step();
    chk("unblank_hi", led_port, 7'h3F);

    value_in = 8'h99;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    chk("r99_acc", value_ready, 1'b0);
    reset = 1'b1;
    step();
    chk("rmid_led", led_port, 7'h00);
    chk("rmid_c", c, 1'b0);
    chk("rmid_ready", value_ready, 1'b1);
    chk("rmid_frame", frame, 1'b0);
    reset = 1'b0;
    cyc = 0;
    step();
    chk("rmid_gap_frame", frame, 1'b0);
    step();
    chk("rmid_first_frame", frame, 1'b1);
    chk("rmid_hi", led_port, 7'h3F);
    to_phase(6);
    chk("rmid_lo", led_port, 7'h3F);
    to_phase(0);
    chk("rmid_next_hi", led_port, 7'h3F);
    chk("rmid_next_ready", value_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
